// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating back-pressure stall counter.
module ex_mem_pipe_reg #(
    parameter int DATA_W   = 32,
    parameter int RD_W     = 4,
    parameter int COND_W   = 4,
    parameter int SIG_W    = 11,
    parameter int SKID     = 1,
    parameter int ZERO_BUB = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COND_W-1:0] br,
    input  logic [COND_W-1:0] br_cond,
    input  logic [COND_W-1:0] alu_cond,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] adder,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RD_W-1:0]   rd,
    input  logic [SIG_W-1:0]  sig,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COND_W-1:0] br_out,
    output logic [COND_W-1:0] br_cond_out,
    output logic [COND_W-1:0] alu_cond_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] adder_out,
    output logic [DATA_W-1:0] wdata_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [SIG_W-1:0]  sig_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW = 3 * COND_W + 3 * DATA_W + RD_W + SIG_W;

    logic [PW-1:0]    in_beat;
    logic [PW-1:0]    m_reg;
    logic [SIG_W-1:0] sig_held;
    logic             valid_int;
    logic             ready_int;
    logic             accept;
    logic             emit;
    logic [CNT_W-1:0] stall_cnt_reg;

    assign in_beat = {br, br_cond, alu_cond, alu, adder, wdata, rd, sig};
    assign accept  = in_valid && ready_int;
    assign emit    = valid_int && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
            state_t        state_reg;
            logic [PW-1:0] s_reg;
            logic          in_ready_reg;

            // in_ready_reg tracks (next state != TWO) so it never depends on out_ready.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg    <= EMPTY;
                    m_reg        <= '0;
                    s_reg        <= '0;
                    in_ready_reg <= 1'b1;
                end else if (flush) begin
                    state_reg    <= EMPTY;
                    in_ready_reg <= 1'b1;
                end else begin
                    case (state_reg)
                        EMPTY: begin
                            if (accept) begin
                                m_reg     <= in_beat;
                                state_reg <= ONE;
                            end
                        end
                        ONE: begin
                            if (accept && emit) begin
                                m_reg <= in_beat;
                            end else if (accept) begin
                                s_reg        <= in_beat;
                                state_reg    <= TWO;
                                in_ready_reg <= 1'b0;
                            end else if (emit) begin
                                state_reg <= EMPTY;
                            end
                        end
                        TWO: begin
                            if (emit) begin
                                m_reg        <= s_reg;
                                state_reg    <= ONE;
                                in_ready_reg <= 1'b1;
                            end
                        end
                        default: begin
                            state_reg    <= EMPTY;
                            in_ready_reg <= 1'b1;
                        end
                    endcase
                end
            end

            assign valid_int = (state_reg != EMPTY);
            assign ready_int = in_ready_reg;
        end else begin : g_single
            logic valid_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    m_reg     <= '0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                end else if (accept) begin
                    m_reg     <= in_beat;
                    valid_reg <= 1'b1;
                end else if (emit) begin
                    valid_reg <= 1'b0;
                end
            end

            assign valid_int = valid_reg;
            assign ready_int = !valid_reg || out_ready;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (valid_int && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign {br_out, br_cond_out, alu_cond_out, alu_out, adder_out, wdata_out, rd_out, sig_held} = m_reg;

    // A bubble must not carry live store/writeback enables into MEM.
    assign sig_out   = ((ZERO_BUB != 0) && !valid_int) ? '0 : sig_held;
    assign out_valid = valid_int;
    assign in_ready  = ready_int;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: skid instance (defaults) and single-slot instance
// (SKID=0, ZERO_BUB=0, CNT_W=4) driven in parallel, each checked against a queue model.
module tb_ex_mem_pipe_reg;

    typedef struct packed {
        logic [3:0]  br;
        logic [3:0]  br_cond;
        logic [3:0]  alu_cond;
        logic [31:0] alu;
        logic [31:0] adder;
        logic [31:0] wdata;
        logic [3:0]  rd;
        logic [10:0] sig;
    } beat_t;

    logic  clk = 1'b0;
    logic  reset, flush, in_valid, out_ready;
    beat_t cur;

    logic        in_ready_a, out_valid_a;
    logic [3:0]  br_out_a, br_cond_out_a, alu_cond_out_a, rd_out_a;
    logic [31:0] alu_out_a, adder_out_a, wdata_out_a;
    logic [10:0] sig_out_a;
    logic [15:0] stall_a;

    logic        in_ready_b, out_valid_b;
    logic [3:0]  br_out_b, br_cond_out_b, alu_cond_out_b, rd_out_b;
    logic [31:0] alu_out_b, adder_out_b, wdata_out_b;
    logic [10:0] sig_out_b;
    logic [3:0]  stall_b;

    int checks = 0;
    int errors = 0;

    // Reference model: each register is a FIFO of bounded capacity.
    beat_t qa[$];
    beat_t qb[$];
    beat_t sha, shb;
    int    cnta, cntb;

    always #5 clk = ~clk;

    ex_mem_pipe_reg dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .br(cur.br), .br_cond(cur.br_cond), .alu_cond(cur.alu_cond),
        .alu(cur.alu), .adder(cur.adder), .wdata(cur.wdata),
        .rd(cur.rd), .sig(cur.sig),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .br_out(br_out_a), .br_cond_out(br_cond_out_a), .alu_cond_out(alu_cond_out_a),
        .alu_out(alu_out_a), .adder_out(adder_out_a), .wdata_out(wdata_out_a),
        .rd_out(rd_out_a), .sig_out(sig_out_a), .stall_cnt(stall_a)
    );

    ex_mem_pipe_reg #(.SKID(0), .ZERO_BUB(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .br(cur.br), .br_cond(cur.br_cond), .alu_cond(cur.alu_cond),
        .alu(cur.alu), .adder(cur.adder), .wdata(cur.wdata),
        .rd(cur.rd), .sig(cur.sig),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .br_out(br_out_b), .br_cond_out(br_cond_out_b), .alu_cond_out(alu_cond_out_b),
        .alu_out(alu_out_b), .adder_out(adder_out_b), .wdata_out(wdata_out_b),
        .rd_out(rd_out_b), .sig_out(sig_out_b), .stall_cnt(stall_b)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.br       = 4'($urandom);
        b.br_cond  = 4'($urandom);
        b.alu_cond = 4'($urandom);
        b.alu      = $urandom;
        b.adder    = $urandom;
        b.wdata    = $urandom;
        b.rd       = 4'($urandom);
        b.sig      = 11'($urandom);
        return b;
    endfunction

    function automatic beat_t obs_a();
        return {br_out_a, br_cond_out_a, alu_cond_out_a, alu_out_a, adder_out_a,
                wdata_out_a, rd_out_a, sig_out_a};
    endfunction

    function automatic beat_t obs_b();
        return {br_out_b, br_cond_out_b, alu_cond_out_b, alu_out_b, adder_out_b,
                wdata_out_b, rd_out_b, sig_out_b};
    endfunction

    task automatic model_step();
        bit acc, emit;
        if (reset) begin
            qa.delete(); qb.delete();
            sha = '0; shb = '0;
            cnta = 0; cntb = 0;
        end else begin
            acc  = in_valid && (qa.size() < 2);
            emit = (qa.size() > 0) && out_ready;
            if (qa.size() > 0 && !out_ready && cnta < 65535) cnta++;
            if (emit) begin
                $display("emit alu=%h adder=%h rd=%h sig=%h", qa[0].alu, qa[0].adder, qa[0].rd, qa[0].sig);
                void'(qa.pop_front());
            end
            if (flush) qa.delete();
            else begin
                if (acc) qa.push_back(cur);
                if (qa.size() > 0) sha = qa[0];
            end

            acc  = in_valid && (qb.size() == 0 || out_ready);
            emit = (qb.size() > 0) && out_ready;
            if (qb.size() > 0 && !out_ready && cntb < 15) cntb++;
            if (emit) void'(qb.pop_front());
            if (flush) qb.delete();
            else begin
                if (acc) qb.push_back(cur);
                if (qb.size() > 0) shb = qb[0];
            end
        end
    endtask

    // One clock: compare outputs at the falling edge, advance the model, resume after the rising edge.
    task automatic cycle(input bit chk);
        beat_t e;
        @(negedge clk);
        if (chk) begin
            check("a_valid", 128'(out_valid_a), 128'(qa.size() > 0));
            check("a_ready", 128'(in_ready_a), 128'(qa.size() < 2));
            e = (qa.size() > 0) ? qa[0] : sha;
            if (qa.size() == 0) e.sig = '0;
            check("a_beat", 128'(obs_a()), 128'(e));
            check("a_stall", 128'(stall_a), 128'(cnta));
            check("b_valid", 128'(out_valid_b), 128'(qb.size() > 0));
            check("b_ready", 128'(in_ready_b), 128'((qb.size() == 0) || out_ready));
            e = (qb.size() > 0) ? qb[0] : shb;
            check("b_beat", 128'(obs_b()), 128'(e));
            check("b_stall", 128'(stall_b), 128'(cntb));
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cur = rand_beat();
        cycle(0);
        cycle(0);
        reset = 1'b0;

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            cur = rand_beat();
            cur.alu = 32'(i);
            if (i > 1) check("t1_alu", 128'(alu_out_a), 128'(i - 1));
            check("t1_ready", 128'(in_ready_a), 128'(1));
            cycle(1);
        end
        in_valid = 1'b0;
        check("t1_alu", 128'(alu_out_a), 128'(8));
        cycle(1);
        cycle(1);

        // Back-pressure fills the skid slot
        reset = 1'b1; cycle(1); reset = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        cur = rand_beat(); cur.alu = 32'd10; cycle(1);
        cur = rand_beat(); cur.alu = 32'd11; cycle(1);
        cur = rand_beat(); cur.alu = 32'd12;
        check("t2_ready_low", 128'(in_ready_a), 128'(0));
        check("t2_m", 128'(alu_out_a), 128'(10));
        cycle(1);
        cycle(1);
        out_ready = 1'b1;
        check("t2_out", 128'(alu_out_a), 128'(10));
        cycle(1);
        check("t2_out", 128'(alu_out_a), 128'(11));
        cycle(1);
        in_valid = 1'b0;
        check("t2_out", 128'(alu_out_a), 128'(12));
        check("t2_stall", 128'(stall_a), 128'(3));
        cycle(1);

        // Flush while both slots are full and a beat is offered
        out_ready = 1'b0; in_valid = 1'b1;
        cur = rand_beat(); cycle(1);
        cur = rand_beat(); cycle(1);
        flush = 1'b1; cur = rand_beat(); cycle(1);
        flush = 1'b0; in_valid = 1'b0;
        check("t3_valid", 128'(out_valid_a), 128'(0));
        check("t3_ready", 128'(in_ready_a), 128'(1));
        check("t3_sig", 128'(sig_out_a), 128'(0));
        out_ready = 1'b1;
        repeat (3) cycle(1);

        // Reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1;
        cur = rand_beat(); cur.adder = 32'hDEADBEEF; cycle(1);
        cur = rand_beat(); cur.adder = 32'hDEADBEEF; cycle(1);
        reset = 1'b1; cycle(1); reset = 1'b0; in_valid = 1'b0;
        check("t4_adder", 128'(adder_out_a), 128'(0));
        check("t4_alu", 128'(alu_out_a), 128'(0));
        check("t4_valid", 128'(out_valid_a), 128'(0));
        check("t4_stall", 128'(stall_a), 128'(0));
        check("t4_ready", 128'(in_ready_a), 128'(1));
        cycle(1);

        // Bubble zeroes the control bundle
        out_ready = 1'b1; in_valid = 1'b1;
        cur = rand_beat(); cur.sig = 11'h7FF; cycle(1);
        in_valid = 1'b0;
        check("t5_sig_live", 128'(sig_out_a), 128'(11'h7FF));
        cycle(1);
        check("t5_sig_bubble", 128'(sig_out_a), 128'(0));
        cycle(1);

        // Stall counter saturation on the 4-bit instance
        reset = 1'b1; cycle(1); reset = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        cur = rand_beat(); cycle(1);
        in_valid = 1'b0;
        repeat (20) cycle(1);
        check("t6_sat", 128'(stall_b), 128'(15));
        check("t6_cnt16", 128'(stall_a), 128'(20));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 99) < 2);
            flush     = ($urandom_range(0, 99) < 5);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            cur = rand_beat();
            cycle(1);
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle(1);
        cycle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
